if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 189 ++++++++++++++++++
 tb/tb_if_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- instruction fetch stage with end-of-program drain detection
//
// Holds the program counter and the IF/ID pipeline register of a classic
// five-stage in-order pipeline. Each unstalled, unredirected cycle it hands
// the word at the current PC to the decode stage. When the halt word is
// fetched it stops fetching and pushes DRAIN_CYCLES bubbles, so everything
// already in flight can retire. It then raises end_program and freezes.
//
// Parameters
//   RESET_PC      byte address fetched first after reset
//   HALT_INSN     instruction word that marks the end of the program
//   DRAIN_CYCLES  unstalled bubble cycles (ID, EX, MEM, WB) before done
//   NOP_INSN      word placed in IF/ID as a bubble (addi x0,x0,0)
//
// Ports
//   clk            in   1   clock, all state changes on the rising edge
//   reset          in   1   synchronous active-high reset
//   imem_addr      out  32  byte address to instruction memory (the PC)
//   imem_rdata     in   32  combinational read data for imem_addr
//   stall          in   1   hazard-unit hold of PC and IF/ID
//   branch_taken   in   1   EX-stage redirect request
//   branch_target  in   32  redirect byte address (low two bits dropped)
//   ifid_pc        out  32  PC of the instruction held in IF/ID
//   ifid_insn      out  32  instruction held in IF/ID
//   ifid_valid     out  1   IF/ID holds a real instruction, not a bubble
//   end_program    out  1   sticky, program has fully drained
//   cycle_count    out  32  cycles from reset release until end_program
// ============================================================================
module if_stage #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] HALT_INSN    = 32'hFFFF_FFFF,
   parameter int          DRAIN_CYCLES = 4,
   parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_insn,
   output logic        ifid_valid,
   output logic        end_program,
   output logic [31:0] cycle_count
);

   // The drain counter only has to count 0 .. DRAIN_CYCLES-1.
   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // State registers and their next-state values
   // ------------------------------------------------------------------------
   state_t            state,       state_next;
   logic [31:0]       pc,          pc_next;
   logic [31:0]       ifid_pc_q,   ifid_pc_next;
   logic [31:0]       ifid_insn_q, ifid_insn_next;
   logic              ifid_valid_q, ifid_valid_next;
   logic [CNT_W-1:0]  drain_cnt,   drain_cnt_next;
   logic [31:0]       cycle_cnt,   cycle_cnt_next;

   logic              is_halt;
   logic [31:0]       redirect_pc;

   assign is_halt     = (imem_rdata == HALT_INSN);
   // Force word alignment of the redirect address.
   assign redirect_pc = branch_target & 32'hFFFF_FFFC;

   // ------------------------------------------------------------------------
   // Next-state and IF/ID logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first (hold the
      // current value), so no path through the case leaves one unassigned
      // and no latch is inferred.
      state_next      = state;
      pc_next         = pc;
      ifid_pc_next    = ifid_pc_q;
      ifid_insn_next  = ifid_insn_q;
      ifid_valid_next = ifid_valid_q;
      drain_cnt_next  = drain_cnt;

      unique case (state)
         RUN: begin
            if (branch_taken) begin
               // Redirect wins over stall: the wrong-path word is squashed.
               pc_next         = redirect_pc;
               ifid_pc_next    = 32'h0000_0000;
               ifid_insn_next  = NOP_INSN;
               ifid_valid_next = 1'b0;
               drain_cnt_next  = '0;
            end else if (stall) begin
               // Hold everything.
            end else if (is_halt) begin
               // Stop fetching; the halt word itself never enters IF/ID.
               ifid_pc_next    = 32'h0000_0000;
               ifid_insn_next  = NOP_INSN;
               ifid_valid_next = 1'b0;
               drain_cnt_next  = '0;
               state_next      = DRAIN;
            end else begin
               pc_next         = pc + 32'd4;
               ifid_pc_next    = pc;
               ifid_insn_next  = imem_rdata;
               ifid_valid_next = 1'b1;
            end
         end

         DRAIN: begin
            if (branch_taken) begin
               // The halt was fetched down a mispredicted path: resume.
               pc_next         = redirect_pc;
               ifid_pc_next    = 32'h0000_0000;
               ifid_insn_next  = NOP_INSN;
               ifid_valid_next = 1'b0;
               drain_cnt_next  = '0;
               state_next      = RUN;
            end else if (stall) begin
               // A stalled cycle does not advance the drain.
            end else begin
               ifid_pc_next    = 32'h0000_0000;
               ifid_insn_next  = NOP_INSN;
               ifid_valid_next = 1'b0;
               if (drain_cnt == DRAIN_LAST) begin
                  state_next = DONE;
               end else begin
                  drain_cnt_next = drain_cnt + 1'b1;
               end
            end
         end

         DONE: begin
            // Frozen; stall and branch_taken are ignored until reset.
         end

         default: begin
            state_next = RUN;
         end
      endcase

      // Counting stops on the edge that enters DONE (that edge still counts).
      cycle_cnt_next = (state != DONE) ? cycle_cnt + 32'd1 : cycle_cnt;
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its next value from the same pre-edge snapshot.
      if (reset) begin
         state        <= RUN;
         pc           <= RESET_PC;
         ifid_pc_q    <= 32'h0000_0000;
         ifid_insn_q  <= NOP_INSN;
         ifid_valid_q <= 1'b0;
         drain_cnt    <= '0;
         cycle_cnt    <= 32'h0000_0000;
      end else begin
         state        <= state_next;
         pc           <= pc_next;
         ifid_pc_q    <= ifid_pc_next;
         ifid_insn_q  <= ifid_insn_next;
         ifid_valid_q <= ifid_valid_next;
         drain_cnt    <= drain_cnt_next;
         cycle_cnt    <= cycle_cnt_next;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign imem_addr   = pc;
   assign ifid_pc     = ifid_pc_q;
   assign ifid_insn   = ifid_insn_q;
   assign ifid_valid  = ifid_valid_q;
   assign end_program = (state == DONE);
   assign cycle_count = cycle_cnt;

endmodule

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage -- directed self-checking bench for if_stage
//
// A 64-word instruction memory answers imem_addr combinationally. Scenarios
// run back to back from one initial block; every expected value below is
// hand-derived from the fetch/drain behaviour with DRAIN_CYCLES = 4.
// ============================================================================
module tb_if_stage;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_insn;
   logic        ifid_valid;
   logic        end_program;
   logic [31:0] cycle_count;

   logic [31:0] mem [0:63];
   int checks;
   int errors;

   if_stage #(
      .RESET_PC     (32'h0000_0000),
      .HALT_INSN    (HALT),
      .DRAIN_CYCLES (4),
      .NOP_INSN     (NOP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .ifid_pc       (ifid_pc),
      .ifid_insn     (ifid_insn),
      .ifid_valid    (ifid_valid),
      .end_program   (end_program),
      .cycle_count   (cycle_count)
   );

   assign imem_rdata = mem[imem_addr[7:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare the full IF/ID view plus the fetch address.
   task automatic expect_ifid(input string name, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic [31:0] e_insn,
                              input logic e_valid);
      checks++;
      if (imem_addr !== e_addr || ifid_pc !== e_pc || ifid_insn !== e_insn ||
          ifid_valid !== e_valid) begin
         errors++;
         $display("FAIL %s: addr=%h pc=%h insn=%h valid=%b, expected addr=%h pc=%h insn=%h valid=%b",
                  name, imem_addr, ifid_pc, ifid_insn, ifid_valid,
                  e_addr, e_pc, e_insn, e_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      step(); step();
      expect_ifid("reset_ifid", 32'h0, 32'h0, NOP, 1'b0);
      checks++;
      if (end_program !== 1'b0 || cycle_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_status: end=%b cc=%0d, expected end=0 cc=0",
                  end_program, cycle_count);
      end
   endtask

   task automatic test_straight_line();
      reset = 1'b0;
      step();
      expect_ifid("straight_c1", 32'h4, 32'h0, 32'h0030_0093, 1'b1);
      step();
      expect_ifid("straight_c2", 32'h8, 32'h4, 32'h0070_0113, 1'b1);
      checks++;
      if (cycle_count !== 32'd2) begin
         errors++;
         $display("FAIL straight_cc: got %0d expected 2", cycle_count);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      step();
      expect_ifid("stall_1", 32'h8, 32'h4, 32'h0070_0113, 1'b1);
      step();
      expect_ifid("stall_2", 32'h8, 32'h4, 32'h0070_0113, 1'b1);
      checks++;
      if (cycle_count !== 32'd4) begin
         errors++;
         $display("FAIL stall_cc: got %0d expected 4", cycle_count);
      end
      stall = 1'b0;
      step();
      expect_ifid("stall_resume", 32'hC, 32'h8, 32'h0020_81B3, 1'b1);
   endtask

   task automatic test_redirect_under_stall();
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0013;
      step();
      expect_ifid("redir_stall", 32'h10, 32'h0, NOP, 1'b0);
      stall = 1'b0; branch_taken = 1'b0;
      step();
      expect_ifid("redir_fetch1", 32'h14, 32'h10, mem[4], 1'b1);
      step();
      expect_ifid("redir_fetch2", 32'h18, 32'h14, mem[5], 1'b1);
   endtask

   task automatic test_halt_cancel();
      // imem_addr is 0x18 and mem[6] is the halt word.
      step();
      expect_ifid("halt_fetch", 32'h18, 32'h0, NOP, 1'b0);
      branch_taken = 1'b1; branch_target = 32'h0000_0008;
      step();
      expect_ifid("cancel_redir", 32'h8, 32'h0, NOP, 1'b0);
      checks++;
      if (end_program !== 1'b0) begin
         errors++;
         $display("FAIL cancel_end: got %b expected 0", end_program);
      end
      branch_taken = 1'b0;
      step();
      expect_ifid("cancel_run", 32'hC, 32'h8, 32'h0020_81B3, 1'b1);
      step(); step(); step();
      expect_ifid("cancel_refetch", 32'h18, 32'h14, mem[5], 1'b1);
   endtask

   task automatic test_real_halt();
      // cycle_count is 14 here; halt edge, one stall, four drain edges -> 20.
      step();
      expect_ifid("halt2_fetch", 32'h18, 32'h0, NOP, 1'b0);
      stall = 1'b1;
      step();
      stall = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++;
         if (end_program !== 1'b0 || ifid_valid !== 1'b0 || ifid_insn !== NOP) begin
            errors++;
            $display("FAIL drain_%0d: end=%b valid=%b insn=%h, expected end=0 valid=0 insn=%h",
                     i, end_program, ifid_valid, ifid_insn, NOP);
         end
      end
      step();
      checks++;
      if (end_program !== 1'b1 || cycle_count !== 32'd20) begin
         errors++;
         $display("FAIL done_entry: end=%b cc=%0d, expected end=1 cc=20",
                  end_program, cycle_count);
      end
      branch_taken = 1'b1; branch_target = 32'h0000_0040; stall = 1'b1;
      step();
      stall = 1'b0;
      step(); step();
      expect_ifid("done_frozen", 32'h18, 32'h0, NOP, 1'b0);
      checks++;
      if (end_program !== 1'b1 || cycle_count !== 32'd20) begin
         errors++;
         $display("FAIL done_hold: end=%b cc=%0d, expected end=1 cc=20",
                  end_program, cycle_count);
      end
      branch_taken = 1'b0;
   endtask

   task automatic test_reset_in_done();
      reset = 1'b1;
      step();
      expect_ifid("rst_done_ifid", 32'h0, 32'h0, NOP, 1'b0);
      checks++;
      if (end_program !== 1'b0 || cycle_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_done_status: end=%b cc=%0d, expected end=0 cc=0",
                  end_program, cycle_count);
      end
      reset = 1'b0;
      step();
      expect_ifid("rst_done_run", 32'h4, 32'h0, 32'h0030_0093, 1'b1);
      checks++;
      if (cycle_count !== 32'd1) begin
         errors++;
         $display("FAIL rst_done_cc: got %0d expected 1", cycle_count);
      end
   endtask

   task automatic test_reset_in_drain();
      branch_taken = 1'b1; branch_target = 32'h0000_0018;
      step();
      branch_taken = 1'b0;
      step();   // halt fetched -> DRAIN
      step();   // first drain cycle
      reset = 1'b1;
      step();
      expect_ifid("rst_drain_ifid", 32'h0, 32'h0, NOP, 1'b0);
      checks++;
      if (end_program !== 1'b0 || cycle_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_drain_status: end=%b cc=%0d, expected end=0 cc=0",
                  end_program, cycle_count);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step();
      // Still fetching: the old drain must not have carried over.
      expect_ifid("rst_drain_run", 32'hC, 32'h8, 32'h0020_81B3, 1'b1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
      mem[0] = 32'h0030_0093;
      mem[1] = 32'h0070_0113;
      mem[2] = 32'h0020_81B3;
      mem[6] = HALT;

      test_reset();
      test_straight_line();
      test_stall();
      test_redirect_under_stall();
      test_halt_cancel();
      test_real_halt();
      test_reset_in_done();
      test_reset_in_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
